qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- Behavioural-synthesisable QSPI flash responder (target side) for the quad fast-read command used by our flash read path.
- Decodes CS/SCK/IO from an initiator and returns bytes from a synchronous-read byte memory.
- Used as an on-chip flash emulator for FPGA bring-up and as the DUT-side model in controller/video benches.
- Runs on its own system clock and oversamples the SPI pins; it does not use SCK as a clock.

Parameters:
- ADDR_BITS, 24: address width, shifted MSB first.
- READ_CMD, 8'hEB: the only accepted command (quad-IO fast read).
- DUMMY_CYCLES, 4: SCK cycles after the mode byte before data starts.
- SYNC_STAGES, 2: synchroniser depth on SCK/CS/IO inputs; minimum 2.

Ports:
- clk, input, 1: system clock. Must be at least 4x the SCK frequency; SCK high and low phases must each be at least SYNC_STAGES+2 clk.
- rstn, input, 1: asynchronous active-low reset.
- spi_clk_in, input, 1: SCK from initiator.
- spi_select_in, input, 1: CS, active low.
- spi_data_in, input, 4: IO[3:0] as seen at the pins.
- spi_data_out, output, 4: IO drive values.
- spi_data_oe, output, 4: IO output enables.
- mem_addr, output, ADDR_BITS: byte address to backing memory.
- mem_rd, output, 1: read strobe. mem_data is valid exactly 1 clk later.
- mem_data, input, 8: read byte.
- active, output, 1: high while CS is low and the transaction is accepted.

Behaviour:
- Reset: all outputs 0 (oe=0, mem_rd=0, mem_addr=0, active=0). State = IDLE. Synchronisers preset SCK=0, CS=1.
- Inputs pass through SYNC_STAGES flops. A rising/falling SCK event is detected from the last two synchronised samples. IO is sampled from the same-depth pipeline, so sampling is aligned with the SCK edge.
- Rising edges only sample inputs; the responder only changes output on detected falling edges.

State machine:
- IDLE: when CS falls → CMD, bit counter 0.
- CMD: shift spi_data_in[0] on 8 rising edges, MSB first.
  - Byte == READ_CMD → ADDR, active=1.
  - Otherwise → IGNORE.
- ADDR: shift one nibble (IO[3:0], IO3 = MSB) per rising edge for ceil(ADDR_BITS/4) edges. Excess leading bits are dropped. On the last edge: mem_addr = address, mem_rd pulses 1 clk → MODE.
- MODE: 2 rising edges, value ignored → DUMMY. oe stays 0.
- DUMMY: DUMMY_CYCLES rising edges. On the falling edge after the last dummy rising edge: oe=4'hF, drive the high nibble of the fetched byte → DATA. If DUMMY_CYCLES=0, the first drive happens on the falling edge after the last mode edge.
- DATA:
  - Each falling edge alternates the low nibble, then the high nibble of the next byte.
  - mem_addr increments and mem_rd pulses when the high nibble of the current byte is driven. This gives one prefetch byte held in a register, so no stall is ever possible.
  - Address wraps from 2^ADDR_BITS-1 to 0.
- IGNORE: oe=0, ignore everything until CS rises.
- CS rising (synchronised) in any state → IDLE within 1 clk: oe=0, active=0, mem_rd=0. A partial nibble or byte is discarded. mem_addr holds its last value.
- CS falling while still in a non-IDLE state (back-to-back with no visible high) cannot happen given the timing constraint and is not handled.
- An SCK edge while CS is high is ignored.
- Reset mid-transaction: immediate IDLE, oe=0.
- Output latency: drive change within SYNC_STAGES+1 clk of the SCK falling edge at the pin.

Decomposition:
- Shared package: command opcode constant, state enum (IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE), nibble-count helper function.
- Sub-module: qspi_pin_sync (SYNC_STAGES synchroniser plus SCK rise/fall edge detector, 6 bits wide). Everything else stays in one module.

Test Plan:
- Read from 0: CMD 0xEB, addr 0x000000, mode 0xA0, 4 dummy, 8 data clocks, memory[i]=i → nibbles 0,0,0,1,0,2,0,3; mem_rd pulses 5 times.
- Start addr 0x123456 with mem[0x123456]=0xA5, mem[0x123457]=0x3C → output A,5,3,C; first mem_addr=0x123456.
- Wrap: addr 0xFFFFFF, read 2 bytes → second mem_addr=0x000000; data mem[0xFFFFFF] then mem[0].
- Bad command 0x03 followed by 20 clocks → oe stays 0, mem_rd never asserted, active=0.
- CS raised mid-data after 3 nibbles → oe=0 within 1 clk of the synchronised CS; the next transaction at addr 0x10 returns mem[0x10] correctly.
- Async reset asserted during DUMMY → all outputs 0 immediately, no clk needed. After release, a full read of 0x000100 succeeds.

Source files
------------

// File: rtl/qspi_flash_responder_pkg.sv
// Shared definitions for the QSPI flash responder: opcode, state encoding and
// address nibble count helper.
package qspi_flash_responder_pkg;

  localparam logic [7:0] QUAD_READ_CMD = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  function automatic int nibble_count(input int addr_bits);
    return (addr_bits + 3) / 4;
  endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Synchroniser for {SCK, CS, IO[3:0]} plus SCK edge detection on the
// synchronised SCK, so IO samples line up with the detected edge.
module qspi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [3:0] io,
  output logic       cs_sync,
  output logic [3:0] io_sync,
  output logic       sck_rise,
  output logic       sck_fall
);

  // Reset looks like an idle bus: SCK low, CS deasserted.
  localparam logic [5:0] PRESET = 6'b01_0000;

  logic [5:0] stage [SYNC_STAGES];
  logic       sck_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= PRESET;
      sck_last <= 1'b0;
    end else begin
      stage[0] <= {sck, cs_n, io};
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      sck_last <= stage[SYNC_STAGES-1][5];
    end
  end

  assign cs_sync  = stage[SYNC_STAGES-1][4];
  assign io_sync  = stage[SYNC_STAGES-1][3:0];
  assign sck_rise = stage[SYNC_STAGES-1][5] & ~sck_last;
  assign sck_fall = ~stage[SYNC_STAGES-1][5] & sck_last;

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI quad fast-read target: decodes command/address from oversampled pins and
// streams bytes from a synchronous-read memory with a one-byte prefetch.
module qspi_flash_responder
  import qspi_flash_responder_pkg::*;
#(
  parameter int         ADDR_BITS    = 24,
  parameter logic [7:0] READ_CMD     = QUAD_READ_CMD,
  parameter int         DUMMY_CYCLES = 4,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_clk_in,
  input  logic                 spi_select_in,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_data,
  output logic                 active
);

  localparam int NIBBLES = nibble_count(ADDR_BITS);
  localparam int SHIFT_W = NIBBLES * 4;

  logic       cs_sync;
  logic [3:0] io_sync;
  logic       sck_rise;
  logic       sck_fall;

  qspi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .sck      (spi_clk_in),
    .cs_n     (spi_select_in),
    .io       (spi_data_in),
    .cs_sync  (cs_sync),
    .io_sync  (io_sync),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  state_t             state;
  logic [7:0]         cnt;
  logic [7:0]         cmd_sr;
  logic [SHIFT_W-1:0] addr_sr;
  logic [7:0]         data_buf;
  logic [3:0]         low_nib;
  logic               high_next;
  logic               rd_pend;
  logic [7:0]         cmd_next;
  logic [SHIFT_W-1:0] addr_next;

  assign cmd_next  = {cmd_sr[6:0], io_sync[0]};
  assign addr_next = {addr_sr[SHIFT_W-5:0], io_sync};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      cmd_sr       <= '0;
      addr_sr      <= '0;
      data_buf     <= '0;
      low_nib      <= '0;
      high_next    <= 1'b1;
      rd_pend      <= 1'b0;
      spi_data_out <= '0;
      spi_data_oe  <= '0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      active       <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      rd_pend <= mem_rd;
      // Memory answers one clk after the strobe; this register is the prefetch slot.
      if (rd_pend) data_buf <= mem_data;

      if (cs_sync && state != IDLE) begin
        state        <= IDLE;
        spi_data_oe  <= '0;
        spi_data_out <= '0;
        active       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (!cs_sync) begin
            state <= CMD;
            cnt   <= '0;
          end
          CMD: if (sck_rise) begin
            cmd_sr <= cmd_next;
            cnt    <= cnt + 8'd1;
            if (cnt == 8'd7) begin
              cnt <= '0;
              if (cmd_next == READ_CMD) begin
                state  <= ADDR;
                active <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR: if (sck_rise) begin
            addr_sr <= addr_next;
            cnt     <= cnt + 8'd1;
            if (cnt == 8'(NIBBLES - 1)) begin
              cnt      <= '0;
              mem_addr <= addr_next[ADDR_BITS-1:0];
              mem_rd   <= 1'b1;
              state    <= MODE;
            end
          end
          MODE: if (sck_rise) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'd1) begin
              cnt       <= '0;
              high_next <= 1'b1;
              state     <= (DUMMY_CYCLES == 0) ? DATA : DUMMY;
            end
          end
          DUMMY: if (sck_rise) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(DUMMY_CYCLES - 1)) begin
              cnt   <= '0;
              state <= DATA;
            end
          end
          // Driving the high nibble frees the prefetch slot, so fetch the next byte then.
          DATA: if (sck_fall) begin
            spi_data_oe <= 4'hF;
            high_next   <= ~high_next;
            if (high_next) begin
              spi_data_out <= data_buf[7:4];
              low_nib      <= data_buf[3:0];
              mem_addr     <= mem_addr + ADDR_BITS'(1);
              mem_rd       <= 1'b1;
            end else begin
              spi_data_out <= low_nib;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: table of directed reads, multi-cycle corner
// sequences and random reads checked against a byte-level flash model.
module tb_qspi_flash_responder;

  localparam int SYNC  = 2;
  localparam int HALF  = 6;
  localparam int DUMMY = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_clk_in = 1'b0;
  logic        spi_select_in = 1'b1;
  logic [3:0]  spi_data_in = 4'h0;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic        active;

  always #5 clk = ~clk;

  qspi_flash_responder #(
    .ADDR_BITS(24), .READ_CMD(8'hEB), .DUMMY_CYCLES(DUMMY), .SYNC_STAGES(SYNC)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .spi_clk_in    (spi_clk_in),
    .spi_select_in (spi_select_in),
    .spi_data_in   (spi_data_in),
    .spi_data_out  (spi_data_out),
    .spi_data_oe   (spi_data_oe),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .active        (active)
  );

  // Flash contents: a few planted bytes, otherwise a fold of the address bytes.
  logic [7:0] ovr [logic [23:0]];

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (ovr.exists(a)) return ovr[a];
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction

  function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = mem_byte(24'(a + 24'(k / 2)));
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  always @(posedge clk) if (mem_rd) mem_data <= mem_byte(mem_addr);

  int          rd_total = 0;
  int          oe_cnt = 0;
  int          act_cnt = 0;
  logic [23:0] rd_log [$];

  always @(negedge clk) begin
    if (mem_rd) begin
      rd_total++;
      rd_log.push_back(mem_addr);
    end
    if (spi_data_oe != 4'h0) oe_cnt++;
    if (active) act_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period in mode 0; SCK is left high so a transaction can end without a trailing fall.
  task automatic sck_cycle(input logic [3:0] drive, output logic [3:0] seen);
    spi_clk_in  = 1'b0;
    spi_data_in = drive;
    wait_clk(HALF);
    seen = spi_data_out;
    spi_clk_in = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic start_txn(input logic [7:0] c, input logic [23:0] a);
    logic [3:0] seen;
    spi_select_in = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) sck_cycle({3'b000, c[7-i]}, seen);
    for (int i = 0; i < 6; i++) sck_cycle(a[23-4*i -: 4], seen);
    sck_cycle(4'hA, seen);
    sck_cycle(4'h0, seen);
  endtask

  task automatic dummy_cycles(input int n);
    logic [3:0] seen;
    for (int i = 0; i < n; i++) sck_cycle(4'h0, seen);
  endtask

  task automatic end_txn(input string tag);
    spi_select_in = 1'b1;
    wait_clk(SYNC + 1);
    check({tag, " oe_after_cs"}, 32'(spi_data_oe), 32'h0);
    check({tag, " active_after_cs"}, 32'(active), 32'h0);
    spi_clk_in = 1'b0;
    wait_clk(HALF);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nibs;
    bit          accept;
    bit          has_golden;
    logic [31:0] golden;
  } txn_t;

  task automatic data_phase(input string tag, input txn_t t, output logic [31:0] packed_nibs);
    logic [3:0] seen;
    packed_nibs = '0;
    for (int k = 0; k < t.nibs; k++) begin
      sck_cycle(4'h0, seen);
      packed_nibs = {packed_nibs[27:0], seen};
      if (t.accept) check($sformatf("%s nib%0d", tag, k), 32'(seen), 32'(exp_nib(t.addr, k)));
    end
  endtask

  task automatic run_txn(input string tag, input txn_t t);
    int          base_rd, base_log, base_oe, base_act, exp_rd, got_rd;
    logic [31:0] packed_nibs;
    base_rd  = rd_total;
    base_log = rd_log.size();
    base_oe  = oe_cnt;
    base_act = act_cnt;
    start_txn(t.cmd, t.addr);
    dummy_cycles(DUMMY);
    check({tag, " oe_before_data"}, 32'(oe_cnt - base_oe), 32'h0);
    data_phase(tag, t, packed_nibs);
    if (t.accept && t.has_golden) check({tag, " golden"}, packed_nibs, t.golden);
    if (t.accept && t.nibs > 0) check({tag, " oe_in_data"}, 32'(spi_data_oe), 32'hF);
    end_txn(tag);
    got_rd = rd_total - base_rd;
    if (t.accept) begin
      exp_rd = 1 + (t.nibs + 1) / 2;
      check({tag, " rd_count"}, 32'(got_rd), 32'(exp_rd));
      for (int i = 0; i < exp_rd && i < got_rd; i++)
        check($sformatf("%s rd_addr%0d", tag, i), 32'(rd_log[base_log+i]), 32'(24'(t.addr + 24'(i))));
      check({tag, " active_seen"}, 32'(act_cnt != base_act), 32'h1);
    end else begin
      check({tag, " rd_count"}, 32'(got_rd), 32'h0);
      check({tag, " oe_never"}, 32'(oe_cnt - base_oe), 32'h0);
      check({tag, " active_never"}, 32'(act_cnt - base_act), 32'h0);
    end
  endtask

  txn_t tbl [5];

  initial begin
    txn_t        t;
    logic [31:0] packed_nibs;
    int          r;

    ovr[24'h123456] = 8'hA5;
    ovr[24'h123457] = 8'h3C;
    ovr[24'hFFFFFF] = 8'h96;

    tbl[0] = '{cmd: 8'hEB, addr: 24'h000000, nibs: 8, accept: 1'b1, has_golden: 1'b1, golden: 32'h00010203};
    tbl[1] = '{cmd: 8'hEB, addr: 24'h123456, nibs: 4, accept: 1'b1, has_golden: 1'b1, golden: 32'h0000A53C};
    tbl[2] = '{cmd: 8'hEB, addr: 24'hFFFFFF, nibs: 4, accept: 1'b1, has_golden: 1'b1, golden: 32'h00009600};
    tbl[3] = '{cmd: 8'h03, addr: 24'h000000, nibs: 8, accept: 1'b0, has_golden: 1'b0, golden: 32'h0};
    tbl[4] = '{cmd: 8'hEB, addr: 24'h000010, nibs: 6, accept: 1'b1, has_golden: 1'b1, golden: 32'h00101112};

    wait_clk(3);
    check("reset oe", 32'(spi_data_oe), 32'h0);
    check("reset data_out", 32'(spi_data_out), 32'h0);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    check("reset mem_rd", 32'(mem_rd), 32'h0);
    check("reset active", 32'(active), 32'h0);
    rstn = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 4; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // CS raised after three data nibbles, then a fresh read must be clean.
    t = '{cmd: 8'hEB, addr: 24'h000020, nibs: 3, accept: 1'b1, has_golden: 1'b0, golden: 32'h0};
    start_txn(t.cmd, t.addr);
    dummy_cycles(DUMMY);
    data_phase("abort", t, packed_nibs);
    check("abort oe_in_data", 32'(spi_data_oe), 32'hF);
    end_txn("abort");
    run_txn("tbl4", tbl[4]);

    // Asynchronous reset in the dummy phase.
    start_txn(8'hEB, 24'h5A5A5A);
    dummy_cycles(2);
    check("pre_reset active", 32'(active), 32'h1);
    check("pre_reset mem_addr", 32'(mem_addr), 32'h5A5A5A);
    #2 rstn = 1'b0;
    #1;
    check("async_reset oe", 32'(spi_data_oe), 32'h0);
    check("async_reset active", 32'(active), 32'h0);
    check("async_reset mem_addr", 32'(mem_addr), 32'h0);
    check("async_reset mem_rd", 32'(mem_rd), 32'h0);
    spi_select_in = 1'b1;
    spi_clk_in    = 1'b0;
    wait_clk(4);
    rstn = 1'b1;
    wait_clk(4);
    t = '{cmd: 8'hEB, addr: 24'h000100, nibs: 8, accept: 1'b1, has_golden: 1'b0, golden: 32'h0};
    run_txn("after_reset", t);

    for (int i = 0; i < 6; i++) begin
      t.cmd = 8'hEB;
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, 255));
        t.cmd = (r == 'hEB) ? 8'h03 : 8'(r);
      end
      t.addr       = 24'($urandom());
      t.nibs       = int'($urandom_range(1, 10));
      t.accept     = (t.cmd == 8'hEB);
      t.has_golden = 1'b0;
      t.golden     = 32'h0;
      run_txn($sformatf("rand%0d", i), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
